btb_update_gen: RTL and testbench

- Producer side of the BTB update interface.
- Collects resolved jump-register mispredictions from the branch unit and buffers them in a small de-duplicating queue.
- Emits one `ariane_pkg::btb_update_t` per accepted handshake toward the BTB.
- Sits between the execute-stage branch unit and the frontend BTB. It absorbs cycles where the BTB write port is unavailable (FPGA BRAM port busy, post-flush hold).

---
 rtl/btb_update_gen_pkg.sv | 45 ++++
 rtl/btb_update_gen.sv | 206 ++++++++++++++++++++
 tb/tb_btb_update_gen.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_gen_pkg.sv
// -----------------------------------------------------------------------------
// btb_update_gen_pkg
//   Shared types and constants for the BTB update producer.
//   - VLEN                : virtual address width of PCs and targets
//   - BTB_UPD_QUEUE_DEPTH : default depth of the update queue
//   - cf_t                : control-flow type of a resolved instruction
//   - btb_update_t        : {valid, pc, target_address} presented to the BTB
//   - btb_entry_t         : payload of one queued update
//   - is_btb_req()        : qualifies a resolved instruction as a BTB update
// -----------------------------------------------------------------------------
package btb_update_gen_pkg;

  localparam int unsigned VLEN                = 64;
  localparam int unsigned BTB_UPD_QUEUE_DEPTH = 4;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
  } btb_update_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target;
  } btb_entry_t;

  // Only mispredicted indirect jumps train the BTB; nothing is learned while
  // the core is in debug mode or while the pipeline is being flushed.
  function automatic logic is_btb_req(input logic resolved_valid,
                                      input logic mispredict,
                                      input cf_t  cf,
                                      input logic debug_mode,
                                      input logic flush);
    return resolved_valid && mispredict && (cf == JumpR) && !debug_mode && !flush;
  endfunction

endpackage

// File: rtl/btb_update_gen.sv
// -----------------------------------------------------------------------------
// btb_update_gen
//   Producer side of the BTB update interface. Mispredicted jump-register
//   resolutions are buffered in a small de-duplicating circular queue and
//   emitted toward the BTB one per valid/ready handshake.
//
// Parameters
//   DEPTH     : queue entries (power of two, >= 2)
//   CNT_WIDTH : width of the saturating drop counter
//
// Ports
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   flush_i             : discard every queued update
//   debug_mode_i        : core in debug mode (no enqueue, no output valid)
//   resolved_valid_i    : branch unit resolved a control-flow instruction
//   resolved_pc_i       : PC of the resolved instruction
//   resolved_target_i   : actual target address
//   resolved_cf_i       : control-flow type
//   mispredict_i        : prediction was wrong
//   btb_update_o        : {valid, pc, target_address} toward the BTB
//   btb_ready_i         : BTB accepts the update this cycle
//   full_o              : queue holds DEPTH entries
//   drop_cnt_o          : saturating count of requests dropped while full
// -----------------------------------------------------------------------------
module btb_update_gen
  import btb_update_gen_pkg::*;
#(
  parameter int unsigned DEPTH     = BTB_UPD_QUEUE_DEPTH,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 debug_mode_i,
  input  logic                 resolved_valid_i,
  input  logic [VLEN-1:0]      resolved_pc_i,
  input  logic [VLEN-1:0]      resolved_target_i,
  input  cf_t                  resolved_cf_i,
  input  logic                 mispredict_i,
  output btb_update_t          btb_update_o,
  input  logic                 btb_ready_i,
  output logic                 full_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]     valid_q, valid_d;
  btb_entry_t           entry_q [DEPTH];
  btb_entry_t           entry_d [DEPTH];
  ptr_t                 head_q, head_d;
  ptr_t                 tail_q, tail_d;
  cnt_t                 count_q, count_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // ---------------------------------------------------------------------------
  // Request qualification, handshake and CAM lookup
  // ---------------------------------------------------------------------------
  logic             req;
  logic             head_valid;
  logic             out_valid;
  logic             pop;
  logic             full;
  logic [DEPTH-1:0] hit_vec;
  logic             hit;
  logic             push;
  logic             drop;

  assign req        = is_btb_req(resolved_valid_i, mispredict_i, resolved_cf_i,
                                 debug_mode_i, flush_i);
  assign head_valid = valid_q[head_q];
  // The output is derived only from stored state (plus the debug gate), so a
  // request can become visible no earlier than the cycle after it arrives.
  assign out_valid  = head_valid && !debug_mode_i;
  assign pop        = out_valid && btb_ready_i;
  assign full       = (count_q == cnt_t'(DEPTH));

  // An entry leaving this cycle must not absorb the request: the BTB is
  // already taking the old target, so the new one has to be queued afresh.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid_q[i]
                && (entry_q[i].pc == resolved_pc_i)
                && !(pop && (ptr_t'(i) == head_q));
    end
  end

  assign hit  = |hit_vec;
  assign push = req && !hit && (!full || pop);
  assign drop = req && !hit && full && !pop;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d  = valid_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    entry_d  = entry_q;

    if (flush_i) begin
      // A handshake in this cycle still reaches the BTB; the queue is simply
      // emptied. Payload is left in place since valid bits gate it.
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + ptr_t'(1);
      end

      // De-duplication keeps at most one live entry per PC, so at most one
      // bit of hit_vec is set; refresh its target in place.
      if (req && hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (hit_vec[i]) begin
            entry_d[i].target = resolved_target_i;
          end
        end
      end

      // When full and popping, tail equals head; the pop above cleared the
      // valid bit and the push sets it again for the new occupant.
      if (push) begin
        valid_d[tail_q] = 1'b1;
        entry_d[tail_q] = '{pc: resolved_pc_i, target: resolved_target_i};
        tail_d          = tail_q + ptr_t'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Drop counter survives flush and saturates at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: the entry payload is deliberately not reset; the valid bits and the
  // output gating make stale pc/target values unobservable, and leaving the
  // wide payload reset-free keeps it mappable onto plain storage.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Fields come straight from the head entry, so they are stable while the
  // BTB stalls. The exception is a de-duplicating request that hits the
  // stalled head: the newer target replaces the older one, since the older
  // one is already known to be wrong.
  always_comb begin
    btb_update_o = '0;
    if (head_valid) begin
      btb_update_o.valid          = out_valid;
      btb_update_o.pc             = entry_q[head_q].pc;
      btb_update_o.target_address = entry_q[head_q].target;
    end
  end

  assign full_o     = full;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_btb_update_gen.sv
// -----------------------------------------------------------------------------
// tb_btb_update_gen
//   Self-checking bench for btb_update_gen. A queue-based reference model
//   tracks the expected BTB update stream and is compared with the DUT on
//   every falling edge; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_btb_update_gen;
  import btb_update_gen_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CNT_WIDTH = 8;
  localparam int          DROP_MAX  = (1 << CNT_WIDTH) - 1;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 debug;
  logic                 rv;
  logic [VLEN-1:0]      pc;
  logic [VLEN-1:0]      target;
  cf_t                  cf;
  logic                 misp;
  btb_update_t          upd;
  logic                 ready;
  logic                 full;
  logic [CNT_WIDTH-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  btb_update_gen #(
    .DEPTH    (DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .debug_mode_i     (debug),
    .resolved_valid_i (rv),
    .resolved_pc_i    (pc),
    .resolved_target_i(target),
    .resolved_cf_i    (cf),
    .mispredict_i     (misp),
    .btb_update_o     (upd),
    .btb_ready_i      (ready),
    .full_o           (full),
    .drop_cnt_o       (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an ordered list of pending updates plus a drop tally.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] tgt;
  } ment_t;

  ment_t m_q[$];
  int    m_drop;
  bit    m_qual;
  int    m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_drop = 0;
    end else begin
      m_qual = rv && misp && (cf == JumpR) && !debug && !flush;
      // The BTB consumes the oldest update whenever one is shown and accepted.
      if (m_q.size() > 0 && !debug && ready) void'(m_q.pop_front());
      if (flush) begin
        m_q.delete();
      end else if (m_qual) begin
        m_idx = -1;
        foreach (m_q[i]) if (m_q[i].pc == pc) m_idx = i;
        if (m_idx >= 0)                 m_q[m_idx].tgt = target;
        else if (m_q.size() < DEPTH)    m_q.push_back('{pc, target});
        else if (m_drop < DROP_MAX)     m_drop++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_valid",  64'(upd.valid),          64'(m_q.size() > 0 && !debug));
      check("cmp_pc",     upd.pc,                  (m_q.size() > 0) ? m_q[0].pc  : '0);
      check("cmp_target", upd.target_address,      (m_q.size() > 0) ? m_q[0].tgt : '0);
      check("cmp_full",   64'(full),               64'(m_q.size() == DEPTH));
      check("cmp_drop",   64'(drop_cnt),           64'(m_drop));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
    rv    = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send(input logic [VLEN-1:0] p, input logic [VLEN-1:0] t);
    rv     = 1'b1;
    misp   = 1'b1;
    cf     = JumpR;
    pc     = p;
    target = t;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    flush  = 1'b0;
    debug  = 1'b0;
    rv     = 1'b0;
    pc     = '0;
    target = '0;
    cf     = JumpR;
    misp   = 1'b1;
    ready  = 1'b0;

    #3;
    check("rst_valid", 64'(upd.valid), 64'd0);
    check("rst_pc",    upd.pc,         64'd0);
    check("rst_full",  64'(full),      64'd0);
    check("rst_drop",  64'(drop_cnt),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // 1: single request, BTB ready.
    ready = 1'b1;
    send(64'h8000_0100, 64'h8000_0400);
    check("t1_valid",  64'(upd.valid),         64'd1);
    check("t1_pc",     upd.pc,                 64'h8000_0100);
    check("t1_target", upd.target_address,     64'h8000_0400);
    cycle();
    check("t1_gone",   64'(upd.valid),         64'd0);

    // 2: fill, overflow by one, then drain in order.
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(64'(i * 'h100), 64'(i * 'h100 + 'h1000));
    check("t2_full",   64'(full),     64'd1);
    check("t2_drop0",  64'(drop_cnt), 64'd0);
    send(64'h500, 64'h1500);
    check("t2_drop1",  64'(drop_cnt), 64'd1);
    check("t2_full1",  64'(full),     64'd1);
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t2_drain_valid", 64'(upd.valid), 64'd1);
      check("t2_drain_pc",    upd.pc,         64'(i * 'h100));
      cycle();
    end
    check("t2_empty",  64'(upd.valid), 64'd0);

    // 3: same PC twice while stalled updates the target in place.
    ready = 1'b0;
    send(64'h200, 64'h900);
    check("t3_tgt_a",  upd.target_address, 64'h900);
    send(64'h200, 64'hA00);
    check("t3_tgt_b",  upd.target_address, 64'hA00);
    check("t3_pc",     upd.pc,             64'h200);
    ready = 1'b1;
    cycle();
    check("t3_single", 64'(upd.valid),     64'd0);

    // 4: non-qualifying requests, then debug mode holding an entry.
    ready = 1'b0;
    cf = Branch; rv = 1'b1; pc = 64'h600; target = 64'h6600;
    cycle();
    cf = JumpR;
    check("t4_branch", 64'(upd.valid), 64'd0);
    misp = 1'b0; rv = 1'b1;
    cycle();
    misp = 1'b1;
    check("t4_nomisp", 64'(upd.valid), 64'd0);
    debug = 1'b1; rv = 1'b1;
    cycle();
    debug = 1'b0;
    check("t4_debug",  64'(upd.valid), 64'd0);
    check("t4_drop",   64'(drop_cnt),  64'd1);
    send(64'h700, 64'h7700);
    check("t4_queued", 64'(upd.valid), 64'd1);
    debug = 1'b1;
    ready = 1'b1;
    #1;
    check("t4_hidden", 64'(upd.valid), 64'd0);
    repeat (3) cycle();
    check("t4_hidden2", 64'(upd.valid), 64'd0);
    debug = 1'b0;
    #1;
    check("t4_resume_valid", 64'(upd.valid), 64'd1);
    check("t4_resume_pc",    upd.pc,         64'h700);
    cycle();
    check("t4_drained", 64'(upd.valid), 64'd0);

    // 5: flush with a simultaneous request.
    ready = 1'b0;
    send(64'h10, 64'h1010);
    send(64'h20, 64'h1020);
    send(64'h30, 64'h1030);
    flush = 1'b1;
    rv = 1'b1; pc = 64'h40; target = 64'h1040;
    cycle();
    check("t5_valid", 64'(upd.valid), 64'd0);
    check("t5_full",  64'(full),      64'd0);
    check("t5_drop",  64'(drop_cnt),  64'd1);
    ready = 1'b1;
    cycle();
    check("t5_empty", 64'(upd.valid), 64'd0);

    // 6: full queue, pop and push in the same cycle.
    ready = 1'b0;
    send(64'hA00, 64'h1A00);
    send(64'hB00, 64'h1B00);
    send(64'hC00, 64'h1C00);
    check("t6_notfull", 64'(full), 64'd0);
    send(64'hD00, 64'h1D00);
    check("t6_full",    64'(full), 64'd1);
    ready = 1'b1;
    send(64'hE00, 64'h1E00);
    check("t6_still_full", 64'(full),     64'd1);
    check("t6_nodrop",     64'(drop_cnt), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("t6_order", upd.pc, 64'('hB00 + i * 'h100));
      cycle();
    end
    check("t6_empty", 64'(upd.valid), 64'd0);

    // Drop counter saturation.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send(64'('h2000 + i * 'h10), 64'h3000);
    for (int i = 0; i < 260; i++) send(64'('h10_0000 + i * 4), 64'h4000);
    check("sat_drop", 64'(drop_cnt), 64'(DROP_MAX));

    // Asynchronous reset mid-operation.
    rst_n = 1'b0;
    #1;
    check("rst2_valid", 64'(upd.valid), 64'd0);
    check("rst2_full",  64'(full),      64'd0);
    check("rst2_drop",  64'(drop_cnt),  64'd0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
